// File: rtl/move_seq_player.sv
// move_seq_player: samples packed 4-move sequences into a move FIFO, issues one move per handshake,
// and feeds the reverse of the last accepted move back to the generator.
module move_seq_player #(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic [7:0]    seq_in,
  output logic          seq_take,
  output logic [1:0]    restrected,
  output logic [1:0]    move_out,
  output logic          move_valid,
  input  logic          move_ready,
  output logic [CW-1:0] count,
  output logic [15:0]   issued
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop;
  assign move_valid = count != '0;
  assign pop = move_valid && move_ready;
  // free-space check ignores a same-cycle pop, so four slots must already be free
  assign seq_take = en && !flush && (count <= CW'(DEPTH - 4));
  assign move_out = mem[rd_ptr];
  always_ff @(posedge clk)
    if (seq_take)
      for (int i = 0; i < 4; i++) mem[wr_ptr + AW'(i)] <= seq_in[7-2*i -: 2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      restrected <= 2'b00;
      issued <= '0;
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + (seq_take ? CW'(4) : CW'(0)) - CW'(pop);
      if (seq_take) begin
        wr_ptr <= wr_ptr + AW'(4);
        restrected <= seq_in[1:0] ^ 2'b10;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        issued <= issued + 16'd1;
      end
    end
endmodule
